// File: rtl/serial_link_pkg.sv
// Shared definitions for the board-to-board serial link.
// Contents:
//   DefaultClksPerBit - line bit period in link-clock cycles, common to both sides of the link
//   rx_state_t        - receiver FSM states
//   even_parity()     - parity bit that makes the given vector even (XOR of all bits)
package serial_link_pkg;

  localparam int unsigned DefaultClksPerBit = 100;

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StPar,
    StCheck,
    StDrain,
    StHold
  } rx_state_t;

  // Returns 1 when the vector holds an odd number of ones. Callers zero-extend.
  function automatic logic even_parity(input logic [63:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous input.
// Ports:
//   clk - destination clock
//   d   - asynchronous input
//   q   - input synchronized to clk (two cycles of latency)
// No reset: the chain keeps tracking the line through clr, so the receiver's edge detector
// sees the true line level as soon as clr is released.
module sync2 (
  input  logic clk,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    meta_q <= d;
    sync_q <= meta_q;
  end

  assign q = sync_q;

endmodule

// File: rtl/serial_word_rx.sv
// Receive side of the board-to-board serial link.
// Deserialises one WIDTH-bit word per frame (LSB first, optional even-parity bit) from bs_in,
// framed by the strobe sig_in, and presents it with a one-cycle valid pulse.
// Ports:
//   clk    - link clock
//   clr    - synchronous active-high reset
//   sig_in - frame strobe from the remote board (asynchronous)
//   bs_in  - serial data from the remote board (asynchronous)
//   data   - last good word, held between frames
//   valid  - one-cycle pulse when data updates
//   busy   - high while a frame is received or drained
//   err    - one-cycle pulse on a framing or parity fault
module serial_word_rx
  import serial_link_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
  parameter int unsigned PARITY       = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sig_in,
  input  logic             bs_in,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             busy,
  output logic             err
);

  localparam int unsigned NumBits = WIDTH + PARITY;
  localparam int unsigned CycW    = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW    = $clog2(NumBits + 1);

  localparam logic [CycW-1:0] CycMid   = CycW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CycW-1:0] CycLast  = CycW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] LastData = BitW'(WIDTH - 1);

  logic s_sig;
  logic s_bs;

  sync2 u_sync_sig (
    .clk (clk),
    .d   (sig_in),
    .q   (s_sig)
  );

  sync2 u_sync_bs (
    .clk (clk),
    .d   (bs_in),
    .q   (s_bs)
  );

  rx_state_t            state_q, state_d;
  logic                 hist_q;
  logic [CycW-1:0]      cyc_q, cyc_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic [NumBits-1:0]   sr_q, sr_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  always_comb begin
    state_d = state_q;
    cyc_d   = (cyc_q == CycLast) ? '0 : cyc_q + CycW'(1);
    bit_d   = bit_q;
    sr_d    = sr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Holding the cycle counter at zero aligns it to the strobe edge.
        cyc_d = '0;
        if (s_sig && !hist_q) begin
          state_d = StData;
          bit_d   = '0;
        end
      end

      StData: begin
        if (!s_sig) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else if (cyc_q == CycMid) begin
          sr_d  = {s_bs, sr_q[NumBits-1:1]};
          bit_d = bit_q + BitW'(1);
          if (bit_q == LastData) begin
            state_d = (PARITY != 0) ? StPar : StCheck;
          end
        end
      end

      StPar: begin
        if (!s_sig) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else if (cyc_q == CycMid) begin
          sr_d    = {s_bs, sr_q[NumBits-1:1]};
          bit_d   = bit_q + BitW'(1);
          state_d = StCheck;
        end
      end

      StCheck: begin
        cyc_d   = '0;
        state_d = StDrain;
        // Parity bit sits in the MSB of sr_q, so the XOR of the whole register is the check.
        if (PARITY == 0 || even_parity(64'(sr_q)) == 1'b0) begin
          data_d  = sr_q[WIDTH-1:0];
          valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end

      StDrain: begin
        if (!s_sig) begin
          state_d = StIdle;
        end else if (cyc_q == CycLast) begin
          err_d   = 1'b1;
          state_d = StHold;
        end
      end

      StHold: begin
        if (!s_sig) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
      // History starts high so a strobe already high at reset release is not a frame start.
      hist_q  <= 1'b1;
      cyc_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= s_sig;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;
  assign err   = err_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed bench for serial_word_rx: a default instance (16 bits, parity, 100 clk/bit) and a
// small instance (8 bits, no parity, 10 clk/bit). Timing is counted in posedges; t0 is the
// posedge at which the receiver acts on the synchronized strobe edge.
module tb_serial_word_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr;
  logic        sig_a, bs_a, valid_a, busy_a, err_a;
  logic [15:0] data_a;
  logic        sig_b, bs_b, valid_b, busy_b, err_b;
  logic [7:0]  data_b;

  serial_word_rx u_dut_a (
    .clk    (clk),
    .clr    (clr),
    .sig_in (sig_a),
    .bs_in  (bs_a),
    .data   (data_a),
    .valid  (valid_a),
    .busy   (busy_a),
    .err    (err_a)
  );

  serial_word_rx #(
    .WIDTH        (8),
    .CLKS_PER_BIT (10),
    .PARITY       (0)
  ) u_dut_b (
    .clk    (clk),
    .clr    (clr),
    .sig_in (sig_b),
    .bs_in  (bs_b),
    .data   (data_b),
    .valid  (valid_b),
    .busy   (busy_b),
    .err    (err_b)
  );

  int ncyc = 0;
  always @(posedge clk) ncyc <= ncyc + 1;

  // Event monitors, sampled on the falling edge.
  int          va_n = 0, va_cyc = 0, ea_n = 0, ea_cyc = 0, bfa_cyc = 0;
  logic [15:0] va_data = '0;
  logic        busy_pa = 1'b0;
  int          vb_n = 0, vb_cyc = 0, eb_n = 0;
  logic [7:0]  vb_data = '0;
  int          both_n = 0;

  always @(negedge clk) begin
    if (valid_a) begin
      va_n    <= va_n + 1;
      va_cyc  <= ncyc;
      va_data <= data_a;
    end
    if (err_a) begin
      ea_n   <= ea_n + 1;
      ea_cyc <= ncyc;
    end
    if (busy_pa && !busy_a) bfa_cyc <= ncyc;
    busy_pa <= busy_a;
    if (valid_b) begin
      vb_n    <= vb_n + 1;
      vb_cyc  <= ncyc;
      vb_data <= data_b;
    end
    if (err_b) eb_n <= eb_n + 1;
    if ((valid_a && err_a) || (valid_b && err_b)) both_n <= both_n + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends bits[0..nbits-1], each held for the instance's bit period, then holds the strobe
  // 'extra' cycles longer. clr is pulsed for one cycle at the start of bit clr_at.
  task automatic send(input bit sel, input logic [16:0] bits, input int nbits, input int extra,
                      input int clr_at, output int t0, output int drop);
    int c;
    c = sel ? 10 : 100;
    @(negedge clk);
    t0 = ncyc + 3;
    if (sel) sig_b = 1'b1;
    else sig_a = 1'b1;
    for (int k = 0; k < nbits; k++) begin
      if (sel) bs_b = bits[k];
      else bs_a = bits[k];
      if (k == clr_at) begin
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (c - 1) @(negedge clk);
      end else begin
        repeat (c) @(negedge clk);
      end
    end
    repeat (extra) @(negedge clk);
    if (sel) begin
      sig_b = 1'b0;
      bs_b  = 1'b0;
    end else begin
      sig_a = 1'b0;
      bs_a  = 1'b0;
    end
    drop = ncyc;
  endtask

  int t0, drop, v0, e0;

  initial begin
    clr   = 1'b1;
    sig_a = 1'b0;
    bs_a  = 1'b0;
    sig_b = 1'b0;
    bs_b  = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_data", 32'(data_a), 32'h0);
    chk("rst_valid", 32'(valid_a), 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    chk("rst_err", 32'(err_a), 32'h0);
    clr = 1'b0;
    repeat (5) @(negedge clk);

    // Good frame A5C3 (even parity bit 0).
    v0 = va_n; e0 = ea_n;
    send(1'b0, {1'b0, 16'hA5C3}, 17, 0, -1, t0, drop);
    repeat (6) @(negedge clk);
    chk("good_valid_cnt", va_n - v0, 1);
    chk("good_valid_cyc", va_cyc, t0 + 1651);
    chk("good_pulse_data", 32'(va_data), 32'hA5C3);
    chk("good_data", 32'(data_a), 32'hA5C3);
    chk("good_err_cnt", ea_n - e0, 0);
    chk("good_busy_fall", bfa_cyc, drop + 3);
    chk("good_busy_idle", 32'(busy_a), 32'h0);

    // 0001 with wrong parity bit 0.
    v0 = va_n; e0 = ea_n;
    send(1'b0, {1'b0, 16'h0001}, 17, 0, -1, t0, drop);
    repeat (6) @(negedge clk);
    chk("par_err_cnt", ea_n - e0, 1);
    chk("par_err_cyc", ea_cyc, t0 + 1651);
    chk("par_valid_cnt", va_n - v0, 0);
    chk("par_data_kept", 32'(data_a), 32'hA5C3);

    // FFFF with the strobe dropped after bit 7.
    v0 = va_n; e0 = ea_n;
    send(1'b0, {1'b0, 16'hFFFF}, 8, 0, -1, t0, drop);
    repeat (6) @(negedge clk);
    chk("drop_err_cnt", ea_n - e0, 1);
    chk("drop_err_cyc", ea_cyc, t0 + 800);
    chk("drop_valid_cnt", va_n - v0, 0);
    chk("drop_data_kept", 32'(data_a), 32'hA5C3);
    chk("drop_busy_idle", 32'(busy_a), 32'h0);

    // Recovery frame 1234 (five ones, parity bit 1).
    v0 = va_n; e0 = ea_n;
    send(1'b0, {1'b1, 16'h1234}, 17, 0, -1, t0, drop);
    repeat (6) @(negedge clk);
    chk("recov_valid_cnt", va_n - v0, 1);
    chk("recov_data", 32'(data_a), 32'h1234);
    chk("recov_err_cnt", ea_n - e0, 0);

    // 0F0F with the strobe held 300 cycles past the parity bit.
    v0 = va_n; e0 = ea_n;
    send(1'b0, {1'b0, 16'h0F0F}, 17, 300, -1, t0, drop);
    repeat (6) @(negedge clk);
    chk("hold_valid_cnt", va_n - v0, 1);
    chk("hold_valid_cyc", va_cyc, t0 + 1651);
    chk("hold_data", 32'(data_a), 32'h0F0F);
    chk("hold_err_cnt", ea_n - e0, 1);
    chk("hold_err_cyc", ea_cyc, t0 + 1751);
    chk("hold_busy_fall", bfa_cyc, drop + 3);

    // clr pulsed during bit 5 while the strobe stays high.
    v0 = va_n; e0 = ea_n;
    send(1'b0, {1'b1, 16'h8000}, 17, 0, 5, t0, drop);
    repeat (6) @(negedge clk);
    chk("clr_data", 32'(data_a), 32'h0);
    chk("clr_valid_cnt", va_n - v0, 0);
    chk("clr_err_cnt", ea_n - e0, 0);
    chk("clr_busy", 32'(busy_a), 32'h0);
    v0 = va_n;
    send(1'b0, {1'b1, 16'h8000}, 17, 0, -1, t0, drop);
    repeat (6) @(negedge clk);
    chk("after_clr_valid_cnt", va_n - v0, 1);
    chk("after_clr_data", 32'(data_a), 32'h8000);

    // Back-to-back 00FF / FF00 with a 3-cycle strobe gap.
    v0 = va_n; e0 = ea_n;
    send(1'b0, {1'b0, 16'h00FF}, 17, 0, -1, t0, drop);
    chk("b2b1_valid_cyc", va_cyc, t0 + 1651);
    chk("b2b1_data", 32'(va_data), 32'h00FF);
    repeat (2) @(negedge clk);
    send(1'b0, {1'b0, 16'hFF00}, 17, 0, -1, t0, drop);
    repeat (6) @(negedge clk);
    chk("b2b2_valid_cyc", va_cyc, t0 + 1651);
    chk("b2b2_data", 32'(data_a), 32'hFF00);
    chk("b2b_valid_cnt", va_n - v0, 2);
    chk("b2b_err_cnt", ea_n - e0, 0);

    // Small instance: 8 bits, no parity, 10 clk/bit, frames 5A / C3 with a 3-cycle gap.
    v0 = vb_n; e0 = eb_n;
    send(1'b1, {9'b0, 8'h5A}, 8, 0, -1, t0, drop);
    chk("small1_valid_cyc", vb_cyc, t0 + 76);
    chk("small1_data", 32'(vb_data), 32'h5A);
    repeat (2) @(negedge clk);
    send(1'b1, {9'b0, 8'hC3}, 8, 0, -1, t0, drop);
    repeat (6) @(negedge clk);
    chk("small2_valid_cyc", vb_cyc, t0 + 76);
    chk("small2_data", 32'(data_b), 32'hC3);
    chk("small_valid_cnt", vb_n - v0, 2);
    chk("small_err_cnt", eb_n - e0, 0);
    chk("small_busy_idle", 32'(busy_b), 32'h0);

    chk("valid_err_overlap", both_n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
